// File: rtl/fb_writer_if.sv
// Pixel stream, RAM write port and frame status
// bundle between the zoom engine and fb_writer.
interface fb_writer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              START;
  logic              ABORT;
  logic [9:0]        IMG_WIDTH_OUT;
  logic [8:0]        IMG_HEIGHT_OUT;
  logic [DATA_W-1:0] PIX_DATA;
  logic              PIX_VALID;
  logic              PIX_READY;
  logic              W_EN;
  logic [ADDR_W-1:0] W_ADDR;
  logic [DATA_W-1:0] W_DATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output START, ABORT,
    output IMG_WIDTH_OUT, IMG_HEIGHT_OUT,
    output PIX_DATA, PIX_VALID,
    input  PIX_READY,
    input  W_EN, W_ADDR, W_DATA,
    input  BUSY, DONE, ERR
  );

  modport slave (
    input  START, ABORT,
    input  IMG_WIDTH_OUT, IMG_HEIGHT_OUT,
    input  PIX_DATA, PIX_VALID,
    output PIX_READY,
    output W_EN, W_ADDR, W_DATA,
    output BUSY, DONE, ERR
  );
endinterface

// File: rtl/fb_writer.sv
// Frame buffer writer: raster pixel stream to
// linear RAM addresses y*w+x via a running counter.
module fb_writer #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int MAX_PIXELS = 76800
) (
  input logic       CLK,
  input logic       RST_N,
  fb_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        w_q, w_d;
  logic [8:0]        h_q, h_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              w_en_q, w_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [18:0] area;
  logic        reject;
  logic        ready;
  logic        xfer;
  logic        last_x;
  logic        last_y;

  // Only multiply: frame size check at START.
  assign area = 19'(bus.IMG_WIDTH_OUT)
              * 19'(bus.IMG_HEIGHT_OUT);

  assign reject = (bus.IMG_WIDTH_OUT == 10'd0)
               || (bus.IMG_HEIGHT_OUT == 9'd0)
               || (bus.IMG_WIDTH_OUT > 10'd640)
               || (bus.IMG_HEIGHT_OUT > 9'd480)
               || (area > 19'(MAX_PIXELS));

  assign ready  = (state_q == WRITE) && !bus.ABORT;
  assign xfer   = ready && bus.PIX_VALID;
  assign last_x = (x_q == w_q - 10'd1);
  assign last_y = (y_q == h_q - 9'd1);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          w_d   = bus.IMG_WIDTH_OUT;
          h_d   = bus.IMG_HEIGHT_OUT;
          err_d = 1'b0;
          if (reject) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = WRITE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end
        end
      end
      WRITE: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (xfer) begin
          w_en_d   = 1'b1;
          w_addr_d = addr_q;
          w_data_d = bus.PIX_DATA;
          // Counters park on the last pixel.
          if (last_x && last_y) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else if (last_x) begin
            x_d    = '0;
            y_d    = y_q + 9'd1;
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            x_d    = x_q + 10'd1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.PIX_READY = ready;
  assign bus.W_EN      = w_en_q;
  assign bus.W_ADDR    = w_addr_q;
  assign bus.W_DATA    = w_data_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: driver queues
// expected writes/done pulses, monitor checks them.
module tb_fb_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_writer_if #(.ADDR_W(17), .DATA_W(8)) bus ();

  fb_writer #(
    .ADDR_W(17),
    .DATA_W(8),
    .MAX_PIXELS(76800)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int err;
    int addr;
    int cyc;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  wr_t   mw;
  done_t md;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, bus.PIX_READY, 0);
    chk({tag, "_wen"}, bus.W_EN, 0);
    chk({tag, "_waddr"}, bus.W_ADDR, 0);
    chk({tag, "_wdata"}, bus.W_DATA, 0);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_done"}, bus.DONE, 0);
    chk({tag, "_err"}, bus.ERR, 0);
  endtask

  // Monitor: every W_EN / DONE must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.W_EN) begin
        wr_count++;
        if (exp_wr.size() == 0) begin
          chk("wen_unexpected", bus.W_EN, 0);
        end else begin
          mw = exp_wr.pop_front();
          chk("w_addr", bus.W_ADDR, mw.addr);
          chk("w_data", bus.W_DATA, mw.data);
        end
      end
      if (bus.DONE) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", bus.DONE, 0);
        end else begin
          md = exp_done.pop_front();
          chk("done_cycle", cyc, md.cyc);
          chk("done_err", bus.ERR, md.err);
          if (md.err == 0) begin
            chk("done_wen", bus.W_EN, 1);
            chk("done_addr", bus.W_ADDR, md.addr);
          end
        end
      end
    end
  end

  // Called and returns at posedge+1; gap<0 means alternate valid.
  task automatic frame(input int w, input int h,
                       input int gap, input int abort_at,
                       input int rst_at, input bit mid_start,
                       input bit full);
    int n, k, s, it, wr0, last_c;
    bit rej, v;
    logic [7:0] d;
    n = w * h;
    rej = (w == 0) || (h == 0) || (w > 640)
       || (h > 480) || (n > 76800);
    s = cyc;
    wr0 = wr_count;
    last_c = 0;
    bus.START = 1'b1;
    bus.IMG_WIDTH_OUT = 10'(w);
    bus.IMG_HEIGHT_OUT = 9'(h);
    if (rej) exp_done.push_back('{err: 1, addr: 0, cyc: s + 1});
    @(negedge clk);
    chk("busy_idle", bus.BUSY, 0);
    chk("ready_idle", bus.PIX_READY, 0);
    @(posedge clk); #1;
    bus.START = 1'b0;
    bus.IMG_WIDTH_OUT = 10'($urandom);
    bus.IMG_HEIGHT_OUT = 9'($urandom);
    if (rej) begin
      @(negedge clk);
      chk("rej_busy", bus.BUSY, 0);
      chk("rej_err", bus.ERR, 1);
      chk("rej_ready", bus.PIX_READY, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_sticky", bus.ERR, 1);
      chk("rej_wen", bus.W_EN, 0);
      @(posedge clk); #1;
      return;
    end
    k = 0;
    it = 0;
    while (k < n) begin
      if (it > 20 * n + 100) begin
        chk("xfer_timeout", k, n);
        break;
      end
      it++;
      if (gap < 0) v = it[0];
      else v = ($urandom_range(99) >= gap);
      d = 8'($urandom);
      bus.PIX_VALID = v;
      bus.PIX_DATA = d;
      bus.ABORT = (k == abort_at);
      bus.START = mid_start && (k == 2);
      if (bus.START) begin
        bus.IMG_WIDTH_OUT = 10'd8;
        bus.IMG_HEIGHT_OUT = 9'd8;
      end
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        exp_wr.delete();
        exp_done.delete();
        bus.PIX_VALID = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (it == 1) begin
        chk("err_clear", bus.ERR, 0);
        chk("busy_write", bus.BUSY, 1);
      end
      chk("pix_ready", bus.PIX_READY, (k == abort_at) ? 0 : 1);
      if (k == abort_at) begin
        @(posedge clk); #1;
        bus.ABORT = 1'b0;
        bus.PIX_VALID = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_ready", bus.PIX_READY, 0);
        @(posedge clk); #1;
        return;
      end
      if (v && bus.PIX_READY) begin
        exp_wr.push_back('{addr: k, data: int'(d)});
        if (k == n - 1) begin
          last_c = cyc;
          exp_done.push_back('{err: 0, addr: n - 1, cyc: cyc + 1});
        end
        k++;
      end
      @(posedge clk); #1;
    end
    bus.PIX_VALID = 1'b0;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    if (full) chk("last_xfer_cycle", last_c, s + n);
    @(negedge clk);
    chk("finish_busy", bus.BUSY, 1);
    chk("finish_ready", bus.PIX_READY, 0);
    @(posedge clk); #1;
    chk("write_count", wr_count - wr0, n);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rw, rh, rg;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.IMG_WIDTH_OUT = '0;
    bus.IMG_HEIGHT_OUT = '0;
    bus.PIX_DATA = '0;
    bus.PIX_VALID = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame(4, 2, 0, -1, -1, 0, 1);
    frame(4, 2, -1, -1, -1, 0, 0);
    frame(400, 200, 0, -1, -1, 0, 0);
    frame(0, 5, 0, -1, -1, 0, 0);
    frame(5, 0, 0, -1, -1, 0, 0);
    frame(641, 1, 0, -1, -1, 0, 0);
    frame(1, 481, 0, -1, -1, 0, 0);
    frame(3, 2, 0, -1, -1, 0, 1);
    frame(8, 8, 0, 5, -1, 0, 0);
    frame(2, 2, 0, -1, -1, 0, 1);
    frame(4, 3, 20, -1, -1, 1, 0);
    frame(4, 4, 0, -1, 3, 0, 0);
    frame(3, 3, 0, -1, -1, 0, 1);
    frame(1, 1, 0, -1, -1, 0, 1);

    repeat (14) begin
      rw = $urandom_range(24, 1);
      rh = $urandom_range(8, 1);
      rg = $urandom_range(60, 0);
      if ($urandom_range(5) == 0) rw = $urandom_range(1023, 641);
      frame(rw, rh, rg, -1, -1, 0, rg == 0);
    end

    frame(320, 240, 0, -1, -1, 0, 1);

    @(negedge clk);
    chk("end_busy", bus.BUSY, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
